// File: rtl/mmu_pkg.sv
// Shared constants for the MMU family: function-code bit, supervisor region map,
// translation FSM states and the faulting page-table entry value.
package mmu_pkg;

   localparam int FC_SUPER_BIT = 2;

   // Last vpn of each supervisor region; regions are contiguous from 0x000.
   localparam logic [11:0] RAM_LAST   = 12'h3FF;
   localparam logic [11:0] ROM_LAST   = 12'h7FF;
   localparam logic [11:0] IO_LAST    = 12'h8FF;
   localparam logic [11:0] BOARD_LAST = 12'h97F;
   localparam logic [11:0] PTAB_LAST  = 12'h9FF;
   localparam logic [11:0] MAP1_LAST  = 12'hAFF;
   localparam logic [11:0] MAP2_LAST  = 12'hBFF;

   localparam logic [5:0] RAM_BASE   = 6'h20;
   localparam logic [5:0] ROM_BASE   = 6'h10;
   localparam logic [7:0] IO_BASE    = 8'h03;
   localparam logic [8:0] BOARD_BASE = 9'h002;
   localparam logic [8:0] PTAB_BASE  = 9'h004;
   localparam logic [3:0] GFX_BASE   = 4'h3;

   localparam logic [15:0] PTE_FAULT = 16'h0000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_RESP
   } state_t;

endpackage

// File: rtl/mmu_super_decode.sv
// Combinational supervisor page decode: fixed regions plus two windows whose
// high PPN bits come from the super_map registers. Shared with the legacy MMU.
module mmu_super_decode
   import mmu_pkg::*;
(
   input  logic [11:0] vpn,
   input  logic [7:0]  super_map_1,
   input  logic [7:0]  super_map_2,
   output logic [15:0] ppn
);

   always_comb begin
      ppn = {GFX_BASE, vpn};
      if (vpn <= RAM_LAST)
         ppn = {RAM_BASE, vpn[9:0]};
      else if (vpn <= ROM_LAST)
         ppn = {ROM_BASE, vpn[9:0]};
      else if (vpn <= IO_LAST)
         ppn = {IO_BASE, vpn[7:0]};
      else if (vpn <= BOARD_LAST)
         ppn = {BOARD_BASE, vpn[6:0]};
      else if (vpn <= PTAB_LAST)
         ppn = {PTAB_BASE, vpn[6:0]};
      else if (vpn <= MAP1_LAST)
         ppn = {super_map_1, vpn[7:0]};
      else if (vpn <= MAP2_LAST)
         ppn = {super_map_2, vpn[7:0]};
   end

endmodule

// File: rtl/mmu_tlb.sv
// Clocked MMU: supervisor decode plus a task-tagged round-robin TLB filled from
// page-table RAM. Define MMU_TLB_STATS_EN to add saturating hit/miss counters.
module mmu_tlb
   import mmu_pkg::*;
#(
   parameter int TASK_BITS   = 4,
   parameter int TLB_ENTRIES = 4,
   parameter int VPN_BITS    = 12,
   parameter int PPN_BITS    = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [VPN_BITS-1:0]           req_vpn,
   input  logic [2:0]                    req_fc,
   input  logic [TASK_BITS-1:0]          task_id,
   input  logic [7:0]                    super_map_1,
   input  logic [7:0]                    super_map_2,
   input  logic                          tlb_flush,
   output logic                          resp_valid,
   output logic [PPN_BITS-1:0]           resp_ppn,
   output logic                          resp_fault,
   output logic                          pt_rd,
   output logic [TASK_BITS+VPN_BITS-1:0] pt_addr,
   input  logic [PPN_BITS-1:0]           pt_data,
   input  logic                          pt_ack
`ifdef MMU_TLB_STATS_EN
   ,
   output logic [15:0]                   stat_hits,
   output logic [15:0]                   stat_misses
`endif
);

   localparam int TAG_W = TASK_BITS + VPN_BITS;
   localparam int PTR_W = $clog2(TLB_ENTRIES);

   state_t                state_q, state_d;
   logic [TAG_W-1:0]      tag_q  [TLB_ENTRIES];
   logic [PPN_BITS-1:0]   data_q [TLB_ENTRIES];
   logic [TLB_ENTRIES-1:0] valid_q;
   logic [PTR_W-1:0]      rep_ptr_q;
   logic [PPN_BITS-1:0]   fill_data_q;
   logic                  flush_pend_q;
   logic [TAG_W-1:0]      req_tag;
   logic                  accept, is_super, hit, fill;
   logic [PPN_BITS-1:0]   hit_ppn, super_ppn;

   assign req_tag  = {task_id, req_vpn};
   assign accept   = req_valid && req_ready;
   assign is_super = req_fc[FC_SUPER_BIT];
   // A flush seen anywhere during the fetch (or on the ack edge) cancels the fill.
   assign fill     = (state_q == ST_FETCH) && pt_ack && (pt_data != PTE_FAULT)
                     && !flush_pend_q && !tlb_flush;

   always_comb begin
      hit     = 1'b0;
      hit_ppn = '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
         if (valid_q[i] && (tag_q[i] == req_tag)) begin
            hit     = 1'b1;
            hit_ppn = data_q[i];
         end
      end
   end

   mmu_super_decode u_super_decode (
      .vpn         (req_vpn),
      .super_map_1 (super_map_1),
      .super_map_2 (super_map_2),
      .ppn         (super_ppn)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid && !is_super && !hit) state_d = ST_FETCH;
         end
         ST_FETCH: if (pt_ack) state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid   <= 1'b0;
         resp_ppn     <= '0;
         resp_fault   <= 1'b0;
         pt_rd        <= 1'b0;
         pt_addr      <= '0;
         flush_pend_q <= 1'b0;
         valid_q      <= '0;
         rep_ptr_q    <= '0;
      end else begin
         resp_valid <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (is_super) begin
                     resp_valid <= 1'b1;
                     resp_ppn   <= super_ppn;
                     resp_fault <= 1'b0;
                  end else if (hit) begin
                     resp_valid <= 1'b1;
                     resp_ppn   <= hit_ppn;
                     resp_fault <= 1'b0;
                  end else begin
                     pt_rd        <= 1'b1;
                     pt_addr      <= req_tag;
                     flush_pend_q <= 1'b0;
                  end
               end
            end
            ST_FETCH: begin
               if (tlb_flush) flush_pend_q <= 1'b1;
               if (pt_ack)    pt_rd        <= 1'b0;
            end
            ST_RESP: begin
               resp_valid <= 1'b1;
               resp_ppn   <= fill_data_q;
               resp_fault <= (fill_data_q == PTE_FAULT);
            end
            default: ;
         endcase
         if (tlb_flush) begin
            valid_q <= '0;
         end else if (fill) begin
            valid_q[rep_ptr_q] <= 1'b1;
            rep_ptr_q          <= rep_ptr_q + 1'b1;
         end
      end
   end

   // Entry payload and fetched data carry no reset; valid bits gate their use.
   always_ff @(posedge clk) begin
      if ((state_q == ST_FETCH) && pt_ack) fill_data_q <= pt_data;
      if (fill) begin
         tag_q[rep_ptr_q]  <= pt_addr;
         data_q[rep_ptr_q] <= pt_data;
      end
   end

`ifdef MMU_TLB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else if (accept && !is_super) begin
         if (hit) begin
            if (stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
         end else begin
            if (stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mmu_tlb.sv
// Self-checking bench for mmu_tlb: directed scenarios plus randomized traffic
// compared against a behavioural TLB / page-table model.
module tb_mmu_tlb;

   localparam int NE = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [11:0] req_vpn = '0;
   logic [2:0]  req_fc = '0;
   logic [3:0]  task_id = '0;
   logic [7:0]  super_map_1 = '0;
   logic [7:0]  super_map_2 = '0;
   logic        tlb_flush = 1'b0;
   logic        resp_valid;
   logic [15:0] resp_ppn;
   logic        resp_fault;
   logic        pt_rd;
   logic [15:0] pt_addr;
   logic [15:0] pt_data = '0;
   logic        pt_ack = 1'b0;

   int errors = 0;
   int checks = 0;

   // Behavioural model: cached translations, round-robin slot, page-table contents.
   logic [15:0] m_tag [NE];
   logic [15:0] m_ppn [NE];
   bit          m_vld [NE];
   int          m_ptr = 0;
   logic [15:0] pt_mem [int];

   mmu_tlb dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_vpn(req_vpn), .req_fc(req_fc), .task_id(task_id),
      .super_map_1(super_map_1), .super_map_2(super_map_2), .tlb_flush(tlb_flush),
      .resp_valid(resp_valid), .resp_ppn(resp_ppn), .resp_fault(resp_fault),
      .pt_rd(pt_rd), .pt_addr(pt_addr), .pt_data(pt_data), .pt_ack(pt_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NE; i++) m_vld[i] = 1'b0;
   endtask

   function automatic logic [15:0] pt_lookup(input int addr);
      if (!pt_mem.exists(addr))
         pt_mem[addr] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
      return pt_mem[addr];
   endfunction

   function automatic logic [15:0] super_ref(input logic [11:0] v, input logic [7:0] m1, input logic [7:0] m2);
      int x;
      x = int'(v);
      if      (x < 'h400) return 16'('h8000 + x % 'h400);
      else if (x < 'h800) return 16'('h4000 + x % 'h400);
      else if (x < 'h900) return 16'('h0300 + x % 'h100);
      else if (x < 'h980) return 16'('h0100 + x % 'h80);
      else if (x < 'hA00) return 16'('h0200 + x % 'h80);
      else if (x < 'hB00) return 16'(int'(m1) * 256 + x % 256);
      else if (x < 'hC00) return 16'(int'(m2) * 256 + x % 256);
      else                return 16'('h3000 + x);
   endfunction

   // One translation. flush_mode: 0 none, 1 on the acceptance cycle, 2 on first pt_rd cycle.
   task automatic xact(input bit sup, input logic [11:0] vpn, input logic [3:0] tid,
                       input logic [7:0] m1, input logic [7:0] m2,
                       input int ack_dly, input int flush_mode, input string tag);
      logic [15:0] tagv, exp_ppn, got_ppn;
      logic        got_fault;
      bit          miss, exp_fault;
      int          hit_idx, got_lat, rd_cnt;
      tagv = {tid, vpn};
      miss = 1'b0;
      exp_fault = 1'b0;
      got_ppn = '0;
      got_fault = 1'b0;
      if (sup) begin
         exp_ppn = super_ref(vpn, m1, m2);
      end else begin
         hit_idx = -1;
         for (int i = 0; i < NE; i++)
            if (m_vld[i] && m_tag[i] == tagv) hit_idx = i;
         if (hit_idx >= 0) begin
            exp_ppn = m_ppn[hit_idx];
         end else begin
            miss = 1'b1;
            exp_ppn = pt_lookup(int'(tagv));
            exp_fault = (exp_ppn == 16'h0000);
         end
      end
      check({tag, " ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_fc = sup ? 3'b101 : 3'b001;
      req_vpn = vpn;
      task_id = tid;
      super_map_1 = m1;
      super_map_2 = m2;
      tlb_flush = (flush_mode == 1);
      @(posedge clk);
      if (flush_mode == 1) model_clear();
      @(negedge clk);
      req_valid = 1'b0;
      tlb_flush = 1'b0;
      req_vpn = 12'($urandom);
      task_id = 4'($urandom);
      super_map_1 = 8'($urandom);
      super_map_2 = 8'($urandom);
      got_lat = -1;
      rd_cnt = 0;
      for (int c = 1; c <= 40 && got_lat < 0; c++) begin
         pt_ack = 1'b0;
         tlb_flush = 1'b0;
         pt_data = 16'($urandom);
         if (resp_valid) begin
            got_lat = c;
            got_ppn = resp_ppn;
            got_fault = resp_fault;
         end else if (pt_rd) begin
            rd_cnt++;
            check({tag, " pt_addr"}, 32'(pt_addr), 32'(tagv));
            if (rd_cnt == 1 && flush_mode == 2) tlb_flush = 1'b1;
            if (rd_cnt == ack_dly) begin
               pt_ack = 1'b1;
               pt_data = exp_ppn;
            end
         end
         if (got_lat < 0) @(negedge clk);
      end
      pt_ack = 1'b0;
      tlb_flush = 1'b0;
      check({tag, " latency"}, 32'(got_lat), miss ? 32'(ack_dly + 2) : 32'd1);
      check({tag, " ppn"}, 32'(got_ppn), 32'(exp_ppn));
      check({tag, " fault"}, 32'(got_fault), 32'(exp_fault));
      check({tag, " pt_rd cycles"}, 32'(rd_cnt), miss ? 32'(ack_dly) : 32'd0);
      @(negedge clk);
      check({tag, " pulse"}, 32'(resp_valid), 32'd0);
      if (miss) begin
         if (flush_mode == 2) begin
            model_clear();
         end else if (exp_ppn != 16'h0000) begin
            m_tag[m_ptr] = tagv;
            m_ppn[m_ptr] = exp_ppn;
            m_vld[m_ptr] = 1'b1;
            m_ptr = (m_ptr + 1) % NE;
         end
      end
   endtask

   initial begin
      logic [11:0] sv [8];
      int fm;
      model_clear();
      repeat (3) @(negedge clk);
      check("rst req_ready", 32'(req_ready), 32'd1);
      check("rst resp_valid", 32'(resp_valid), 32'd0);
      check("rst resp_ppn", 32'(resp_ppn), 32'd0);
      check("rst resp_fault", 32'(resp_fault), 32'd0);
      check("rst pt_rd", 32'(pt_rd), 32'd0);
      check("rst pt_addr", 32'(pt_addr), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      sv = '{12'h3FF, 12'h7FE, 12'h8FF, 12'h97F, 12'h981, 12'hC01, 12'hA00, 12'hB00};
      for (int i = 0; i < 8; i++) xact(1'b1, sv[i], 4'h0, 8'hFF, 8'hFE, 1, 0, "super");

      pt_mem[32'h1002] = 16'h1234;
      xact(1'b0, 12'h002, 4'h1, 8'h00, 8'h00, 3, 0, "miss1");
      xact(1'b0, 12'h002, 4'h1, 8'h00, 8'h00, 3, 0, "hit1");

      pt_mem[32'h4005] = 16'h0000;
      xact(1'b0, 12'h005, 4'h4, 8'h00, 8'h00, 1, 0, "fault");
      xact(1'b0, 12'h005, 4'h4, 8'h00, 8'h00, 2, 0, "fault again");

      pt_mem[32'h3002] = 16'h0BEE;
      xact(1'b0, 12'h002, 4'h3, 8'h00, 8'h00, 1, 0, "task3 miss");
      xact(1'b0, 12'h002, 4'h1, 8'h00, 8'h00, 1, 0, "task1 hit");
      xact(1'b0, 12'h002, 4'h3, 8'h00, 8'h00, 1, 0, "task3 hit");

      // pt_ack while idle must not disturb anything
      pt_ack = 1'b1;
      pt_data = 16'h5555;
      @(negedge clk);
      pt_ack = 1'b0;
      check("stray ack resp_valid", 32'(resp_valid), 32'd0);
      check("stray ack pt_rd", 32'(pt_rd), 32'd0);
      xact(1'b0, 12'h002, 4'h3, 8'h00, 8'h00, 1, 0, "after stray ack");

      // flush coincident with a hit: served from pre-flush contents
      xact(1'b0, 12'h002, 4'h1, 8'h00, 8'h00, 1, 1, "flush hit");
      xact(1'b0, 12'h002, 4'h1, 8'h00, 8'h00, 1, 0, "post flush miss");

      for (int i = 0; i <= NE; i++) pt_mem[32'h2100 + i] = 16'(16'h0A00 + i);
      for (int i = 0; i <= NE; i++) xact(1'b0, 12'(12'h100 + i), 4'h2, 8'h00, 8'h00, 1, 0, "rr fill");
      for (int i = 1; i <= NE; i++) xact(1'b0, 12'(12'h100 + i), 4'h2, 8'h00, 8'h00, 1, 0, "rr hit");
      xact(1'b0, 12'h100, 4'h2, 8'h00, 8'h00, 1, 0, "rr evicted");

      pt_mem[32'h6010] = 16'h0042;
      xact(1'b0, 12'h010, 4'h6, 8'h00, 8'h00, 3, 2, "flush fetch");
      xact(1'b0, 12'h010, 4'h6, 8'h00, 8'h00, 1, 0, "flush fetch again");
      xact(1'b0, 12'h011, 4'h6, 8'h00, 8'h00, 1, 2, "flush on ack");

      // reset during a fetch
      xact(1'b0, 12'h002, 4'h1, 8'h00, 8'h00, 1, 0, "pre-reset");
      req_valid = 1'b1;
      req_fc = 3'b001;
      req_vpn = 12'h777;
      task_id = 4'h5;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("fetch pt_rd", 32'(pt_rd), 32'd1);
      rst_n = 1'b0;
      #1;
      check("reset pt_rd", 32'(pt_rd), 32'd0);
      check("reset req_ready", 32'(req_ready), 32'd1);
      check("reset resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      m_ptr = 0;
      @(negedge clk);
      xact(1'b0, 12'h002, 4'h1, 8'h00, 8'h00, 2, 0, "post-reset miss");

      for (int n = 0; n < 80; n++) begin
         fm = $urandom_range(0, 9);
         fm = (fm == 0) ? 1 : (fm == 1) ? 2 : 0;
         if ($urandom_range(0, 3) == 0)
            xact(1'b1, 12'($urandom), 4'h0, 8'($urandom), 8'($urandom), 1, fm, "rand super");
         else
            xact(1'b0, 12'(12'h200 + $urandom_range(0, 7)), 4'($urandom_range(0, 3)),
                 8'h00, 8'h00, $urandom_range(1, 4), fm, "rand user");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
